// File: rtl/systolic_host_seq.sv
// Host-side sequencer for the 3x3 systolic accelerator: buffers weights, restarts and feeds
// the accelerator, captures its serialized result words and serves them as 16-bit lanes.
module systolic_host_seq #(
  parameter int unsigned LOAD_WORDS   = 5,
  parameter int unsigned RUN_CYCLES   = 9,
  parameter int unsigned RESULT_WORDS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [23:0] act_i,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [3:0]  rd_idx,
  output logic [15:0] rd_data,
  output logic        acc_rst,
  output logic [31:0] acc_data,
  output logic [23:0] acc_in,
  input  logic [31:0] acc_out
);

  localparam int unsigned DW     = 32;
  localparam int unsigned LW     = 16;
  localparam int unsigned IW     = 4;
  localparam int unsigned LANES  = 2 * RESULT_WORDS - 1;
  localparam int unsigned PH_MAX = (LOAD_WORDS > RUN_CYCLES)
                                   ? ((LOAD_WORDS > RESULT_WORDS) ? LOAD_WORDS : RESULT_WORDS)
                                   : ((RUN_CYCLES > RESULT_WORDS) ? RUN_CYCLES : RESULT_WORDS);
  localparam int unsigned CW     = $clog2(PH_MAX + 1);
  localparam int unsigned WW     = $clog2(LOAD_WORDS + 1);
  localparam int unsigned LIW    = $clog2(LOAD_WORDS);
  localparam int unsigned CIW    = $clog2(RESULT_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_LOAD,
    S_RUN,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [WW-1:0] wcnt, wcnt_nx;
  logic          wr_take_c;
  logic          start_take_c;

  logic [LOAD_WORDS-1:0][DW-1:0]     wbuf;
  logic [RESULT_WORDS-1:0][DW-1:0]   cap;
  logic [2*RESULT_WORDS-1:0][LW-1:0] lanes_c;

  // Lane n is the n-th 16-bit slice of the capture buffer, low half of each word first.
  assign lanes_c = cap;

  // Phase sequencing; start is qualified on the fill count before this cycle's write.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    wcnt_nx      = wcnt;
    wr_take_c    = wr_valid && wr_ready;
    start_take_c = (state == S_IDLE) && start && (wcnt == WW'(LOAD_WORDS));
    if (wr_take_c) wcnt_nx = wcnt + WW'(1);
    case (state)
      S_IDLE: begin
        if (start_take_c) state_nx = S_KICK;
      end
      S_KICK: begin
        state_nx = S_LOAD;
        cnt_nx   = '0;
      end
      S_LOAD: begin
        cnt_nx = cnt + CW'(1);
        if (cnt == CW'(LOAD_WORDS - 1)) begin
          state_nx = S_RUN;
          cnt_nx   = '0;
        end
      end
      S_RUN: begin
        cnt_nx = cnt + CW'(1);
        if (cnt == CW'(RUN_CYCLES - 1)) begin
          state_nx = S_CAPTURE;
          cnt_nx   = '0;
        end
      end
      S_CAPTURE: begin
        cnt_nx = cnt + CW'(1);
        if (cnt == CW'(RESULT_WORDS - 1)) begin
          state_nx = S_DONE;
          cnt_nx   = '0;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        wcnt_nx  = '0;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      wcnt  <= wcnt_nx;
    end
  end

  // Outputs and buffers; accelerator-facing signals trail the phase state by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      acc_rst  <= 1'b1;
      acc_data <= '0;
      acc_in   <= '0;
      wbuf     <= '0;
      cap      <= '0;
      rd_data  <= '0;
    end else begin
      wr_ready <= (state_nx == S_IDLE) && (wcnt_nx < WW'(LOAD_WORDS));
      busy     <= (state_nx != S_IDLE);
      done     <= (state == S_DONE);
      acc_rst  <= (state == S_KICK);
      acc_data <= (state == S_LOAD) ? wbuf[LIW'(cnt)] : '0;
      if (start_take_c) acc_in <= act_i;
      if (wr_take_c) wbuf[LIW'(wcnt)] <= wr_data;
      if (state == S_CAPTURE) cap[CIW'(cnt)] <= acc_out;
      rd_data  <= (rd_idx < IW'(LANES)) ? lanes_c[rd_idx] : '0;
    end
  end

endmodule

// File: tb/tb_systolic_host_seq.sv
// Randomized scoreboard bench for systolic_host_seq with a cycle-level accelerator stand-in.
module tb_systolic_host_seq;

  localparam int NLOAD    = 5;
  localparam int RUNC     = 9;
  localparam int NRES     = 5;
  localparam int CAP0     = 2 + NLOAD + RUNC;   // edge offset of the first result capture
  localparam int DONE_LAT = CAP0 + NRES;        // start edge to done

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic [23:0] act_i = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [3:0]  rd_idx = '0;
  logic [15:0] rd_data;
  logic        acc_rst;
  logic [31:0] acc_data;
  logic [23:0] acc_in;
  logic [31:0] acc_out = '0;

  systolic_host_seq dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .act_i(act_i), .start(start), .busy(busy), .done(done), .rd_idx(rd_idx), .rd_data(rd_data),
    .acc_rst(acc_rst), .acc_data(acc_data), .acc_in(acc_in), .acc_out(acc_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model state
  logic [31:0] m_wbuf [NLOAD];
  int          m_wcnt = 0;
  int          idle_from = 0;
  int          ready_from = 0;
  logic [31:0] run_res [NRES];
  logic [31:0] old_cap [NRES];
  logic [31:0] fixed_res [NRES];
  bit          use_fixed = 1'b0;
  bit          run_valid = 1'b0;
  int          run_t = 0;

  bit          exp_rst  [int];
  bit          exp_busy [int];
  bit          exp_wrdy [int];
  logic [31:0] exp_data [int];

  typedef struct { int cyc; logic [23:0] act; } done_t;
  typedef struct { int cyc; logic [15:0] val; } rd_t;
  done_t done_q[$];
  rd_t   rd_q[$];

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endfunction

  function automatic logic [15:0] lane_exp(input logic [3:0] idx, input int e);
    logic [31:0] w;
    int j;
    if (idx > 4'd8) return 16'h0;
    j = int'(idx) >> 1;
    w = (run_valid && e > run_t + CAP0 + j) ? run_res[j] : old_cap[j];
    return idx[0] ? w[31:16] : w[15:0];
  endfunction

  // Accelerator stand-in: result words appear relative to its restart pulse.
  int ak = -1;
  always @(negedge clk) begin
    if (acc_rst) ak = 0;
    else if (ak >= 0) ak++;
    if (ak >= CAP0 - 2 && ak < CAP0 - 2 + NRES) acc_out = run_res[ak - (CAP0 - 2)];
    else acc_out = $urandom;
  end

  task automatic launch(input int t, input logic [23:0] act);
    if (run_valid) for (int j = 0; j < NRES; j++) old_cap[j] = run_res[j];
    for (int j = 0; j < NRES; j++) run_res[j] = use_fixed ? fixed_res[j] : $urandom;
    run_valid = 1'b1;
    run_t = t;
    exp_rst[t + 1] = 1'b1;
    for (int k = 0; k < NLOAD; k++) exp_data[t + 2 + k] = m_wbuf[k];
    for (int c = t; c < t + DONE_LAT; c++) exp_busy[c] = 1'b1;
    done_q.push_back('{t + DONE_LAT, act});
    idle_from = t + DONE_LAT + 1;
    m_wcnt = 0;
  endtask

  // Drive one cycle of inputs and record what the next edge must produce.
  task automatic cycle_in(input logic wv, input logic [31:0] wd, input logic st,
                          input logic [23:0] act, input logic [3:0] idx);
    int e;
    bit idle, wacc, sacc;
    e = cyc + 1;
    wr_valid = wv; wr_data = wd; start = st; act_i = act; rd_idx = idx;
    idle = (e >= idle_from);
    wacc = wv && idle && (m_wcnt < NLOAD) && (e >= ready_from);
    sacc = st && idle && (m_wcnt == NLOAD);
    rd_q.push_back('{e, lane_exp(idx, e)});
    if (wacc) begin
      m_wbuf[m_wcnt] = wd;
      m_wcnt++;
    end
    if (sacc) launch(e, act);
    exp_wrdy[e] = (e + 1 >= idle_from) && (m_wcnt < NLOAD) && (e >= ready_from - 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) cycle_in(1'b0, 32'h0, 1'b0, 24'h0, 4'($urandom_range(0, 15)));
  endtask

  task automatic wait_idle();
    while (cyc + 1 < idle_from) cycle_in(1'b0, 32'h0, 1'b0, 24'($urandom), 4'($urandom_range(0, 15)));
  endtask

  task automatic fill();
    for (int i = 0; i < NLOAD; i++) cycle_in(1'b1, $urandom, 1'b0, 24'($urandom), 4'($urandom_range(0, 15)));
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) cycle_in(1'b0, 32'h0, 1'b0, 24'h0, 4'(i));
  endtask

  task automatic do_reset(input int h);
    int k, m;
    k = cyc;
    m = k + h;
    reset = 1'b1;
    wr_valid = 1'b0;
    start = 1'b0;
    for (int c = k; c < k + 40; c++) begin
      if (exp_busy.exists(c)) exp_busy.delete(c);
      if (exp_data.exists(c)) exp_data.delete(c);
      if (exp_rst.exists(c))  exp_rst.delete(c);
      if (exp_wrdy.exists(c)) exp_wrdy.delete(c);
    end
    for (int c = k; c <= m; c++) begin
      exp_rst[c] = 1'b1;
      exp_wrdy[c] = 1'b0;
    end
    done_q.delete();
    rd_q.delete();
    m_wcnt = 0;
    for (int j = 0; j < NRES; j++) old_cap[j] = 32'h0;
    run_valid = 1'b0;
    idle_from = 0;
    ready_from = m + 2;
    repeat (h) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: per-cycle flags plus queued done and read-port expectations.
  always @(negedge clk) begin : monitor
    bit ed;
    if (cyc > 0) begin
      ed = (done_q.size() > 0) && (done_q[0].cyc == cyc);
      chk("done", 32'(done), 32'(ed));
      if (ed) begin
        chk("acc_in", 32'(acc_in), 32'(done_q[0].act));
        done_q.delete(0);
      end
      chk("acc_rst", 32'(acc_rst), 32'(exp_rst.exists(cyc)));
      chk("busy", 32'(busy), 32'(exp_busy.exists(cyc)));
      chk("acc_data", acc_data, exp_data.exists(cyc) ? exp_data[cyc] : 32'h0);
      if (exp_wrdy.exists(cyc)) chk("wr_ready", 32'(wr_ready), 32'(exp_wrdy[cyc]));
      while (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
        if (rd_q[0].cyc == cyc) chk("rd_data", 32'(rd_data), 32'(rd_q[0].val));
        rd_q.delete(0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    fixed_res = '{32'h00020001, 32'h00040003, 32'h00060005, 32'h00080007, 32'hDEAD0009};
    for (int j = 0; j < NRES; j++) begin
      old_cap[j] = 32'h0;
      run_res[j] = 32'h0;
    end
    for (int j = 0; j < NLOAD; j++) m_wbuf[j] = 32'h0;
    #1;
    do_reset(3);
    idle_cycles(2);

    // Known weights and known result words
    use_fixed = 1'b1;
    for (int i = 0; i < NLOAD; i++) cycle_in(1'b1, 32'(32'h11111111 * (i + 1)), 1'b0, 24'h0, 4'(i));
    cycle_in(1'b0, 32'h0, 1'b1, 24'hABCDEF, 4'h0);
    idle_cycles(22);
    read_all();
    use_fixed = 1'b0;

    // Early start, coincident start, overfill, then activity while busy
    for (int i = 0; i < 3; i++) cycle_in(1'b1, 32'hA0000000 | 32'(i), 1'b0, 24'h0, 4'h1);
    cycle_in(1'b0, 32'h0, 1'b1, 24'h111111, 4'h2);
    cycle_in(1'b1, 32'hA0000003, 1'b0, 24'h0, 4'h3);
    cycle_in(1'b1, 32'hA0000004, 1'b1, 24'h222222, 4'h4);
    cycle_in(1'b1, 32'hA0000005, 1'b0, 24'h0, 4'h5);
    cycle_in(1'b0, 32'h0, 1'b1, 24'h333333, 4'h6);
    for (int i = 0; i < 10; i++) cycle_in(1'b1, $urandom, 1'b1, 24'h444444, 4'($urandom_range(0, 15)));
    wait_idle();
    read_all();

    // Reset while the weights are streaming
    fill();
    cycle_in(1'b0, 32'h0, 1'b1, 24'h555555, 4'h0);
    idle_cycles(4);
    do_reset(2);
    idle_cycles(3);
    read_all();

    // Back-to-back runs with refill
    fill();
    cycle_in(1'b0, 32'h0, 1'b1, 24'($urandom), 4'h0);
    wait_idle();
    fill();
    cycle_in(1'b0, 32'h0, 1'b1, 24'($urandom), 4'h0);
    wait_idle();
    read_all();

    // Random traffic
    for (int i = 0; i < 700; i++) begin
      if (i == 350) do_reset(2);
      cycle_in($urandom_range(0, 99) < 45, $urandom, $urandom_range(0, 9) < 3,
               24'($urandom), 4'($urandom_range(0, 15)));
    end
    wait_idle();
    idle_cycles(30);
    chk("done_pending", 32'(done_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
